// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
// The divider datapath (DIV/DIVU) is built only when MDU_DIV_EN is defined.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int unsigned DW = DATA_WIDTH;
`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW:0]          acc_hi_q, acc_hi_d;
  logic [DW-1:0]        acc_lo_q, acc_lo_d;
  logic [DW-1:0]        opnd_q, opnd_d;
  logic [DW-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic                 dbz_pend_q, dbz_pend_d, done_q, done_d, dbz_q, dbz_d;

  logic          op_mul, op_div, op_signed, a_neg, b_neg, b_zero;
  logic [DW-1:0] a_mag, b_mag;

  assign op_mul    = (op_i == OpMult) || (op_i == OpMultu);
  assign op_div    = DivEn && ((op_i == OpDiv) || (op_i == OpDivu));
  assign op_signed = ~op_i[0];
  assign a_neg     = op_signed & a_i[DW-1];
  assign b_neg     = op_signed & b_i[DW-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign b_zero    = (b_i == '0);

  // acc_hi holds the running partial product (mult) or partial remainder (div);
  // acc_lo shifts out multiplier bits or shifts in quotient bits.
  logic [DW:0] mul_t, div_sh, div_diff;
  assign mul_t    = acc_lo_q[0] ? (acc_hi_q + {1'b0, opnd_q}) : acc_hi_q;
  assign div_sh   = {acc_hi_q[DW-1:0], acc_lo_q[DW-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  logic [2*DW-1:0] prod, prod_fix;
  logic [DW-1:0]   quot_fix, rem_fix;
  assign prod     = {acc_hi_q[DW-1:0], acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q[DW-1:0] : acc_hi_q[DW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          if (op_i == OpMthi) begin
            hi_d = a_i;
          end else if (op_i == OpMtlo) begin
            lo_d = a_i;
          end else if (op_mul || op_div) begin
            acc_hi_d   = '0;
            acc_lo_d   = op_div ? a_mag : b_mag;
            opnd_d     = op_div ? b_mag : a_mag;
            is_div_d   = op_div;
            neg_d      = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            dbz_pend_d = op_div && b_zero;
            cnt_d      = CNT_WIDTH'(DW);
            // A zero divisor skips the iterations entirely.
            state_d    = (op_div && b_zero) ? StFix : StRun;
          end
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_diff[DW] ? div_sh : div_diff;
            acc_lo_d = {acc_lo_q[DW-2:0], ~div_diff[DW]};
          end else begin
            acc_hi_d = {1'b0, mul_t[DW:1]};
            acc_lo_d = {mul_t[0], acc_lo_q[DW-1:1]};
          end
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush_i) begin
          done_d = 1'b1;
          if (dbz_pend_q) begin
            dbz_d = DivEn;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*DW-1:DW];
            lo_d = prod_fix[DW-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized bench for mult_div_unit checked against an arithmetic model.
// Division expectations follow MDU_DIV_EN the same way the design does.
module tb_mult_div_unit;
  localparam int KNone = 0;
  localparam int KLong = 1;
  localparam int KDbz  = 2;

  logic        clk = 1'b0;
  logic        reset, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hi_m, lo_m;

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted op on HI/LO, from plain arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int kind);
    logic [63:0] p;
    int sa, sb;
    kind = KNone;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin p = longint'(sa) * longint'(sb); hi_m = p[63:32]; lo_m = p[31:0]; kind = KLong; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; hi_m = p[63:32]; lo_m = p[31:0]; kind = KLong; end
      3'b010, 3'b011: begin
`ifdef MDU_DIV_EN
        if (b == 32'h0) begin
          kind = KDbz;
        end else begin
          kind = KLong;
          if (op == 3'b011) begin
            lo_m = a / b;
            hi_m = a % b;
          end else if (a == 32'h8000_0000 && sb == -1) begin
            lo_m = a;
            hi_m = 32'h0;
          end else begin
            lo_m = sa / sb;
            hi_m = sa % sb;
          end
        end
`endif
      end
      3'b100: hi_m = a;
      3'b101: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue one start and wait (bounded) for done; operands are scrambled after accept.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output bit got_done, output bit got_dbz);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    step();
    start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    busy_n = 0; got_done = 1'b0; got_dbz = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        got_done = 1'b1;
        got_dbz = div_by_zero_o;
        break;
      end
      if (busy_o) busy_n++;
      step();
    end
  endtask

  task automatic drive_move(input logic [2:0] op, input logic [31:0] a);
    int k;
    model_op(op, a, 32'h0, k);
    start_i = 1'b1; op_i = op; a_i = a;
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'b0; a_i = 32'h0; b_i = 32'h0;
    repeat (2) step();
    n_checks++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
    n_checks++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (div_by_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero_o); end
    reset = 1'b0; hi_m = 32'h0; lo_m = 32'h0;
    step();
  endtask

  task automatic test_mul_directed();
    int bn, k; bit gd, gz;
    model_op(3'b000, 32'hFFFF_FFFD, 32'h7, k);
    do_op(3'b000, 32'hFFFF_FFFD, 32'h7, bn, gd, gz);
    n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b want 1", gd); end
    n_checks++; if (bn != 33) begin n_fail++; $display("FAIL mult_busy_len: got %0d want 33", bn); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want FFFFFFFF", hi_o); end
    n_checks++; if (lo_o !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want FFFFFFEB", lo_o); end
    step();
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done_o); end
    model_op(3'b001, 32'hFFFF_FFFF, 32'h2, k);
    do_op(3'b001, 32'hFFFF_FFFF, 32'h2, bn, gd, gz);
    n_checks++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", hi_o); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want FFFFFFFE", lo_o); end
    drive_move(3'b101, 32'h1234_5678);
    n_checks++; if (lo_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_lo: got %h want 12345678", lo_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy_o); end
    n_checks++; if (hi_o !== 32'h1) begin n_fail++; $display("FAIL mtlo_hi: got %h want 00000001", hi_o); end
    step();
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL mtlo_done: got %b want 0", done_o); end
  endtask

  task automatic test_div();
    int bn, k, nd; bit gd, gz;
`ifdef MDU_DIV_EN
    model_op(3'b010, 32'hFFFF_FFF9, 32'h2, k);
    do_op(3'b010, 32'hFFFF_FFF9, 32'h2, bn, gd, gz);
    n_checks++; if (bn != 33 || gd !== 1'b1) begin n_fail++; $display("FAIL div_timing: got busy %0d done %b want 33 1", bn, gd); end
    n_checks++; if (lo_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want FFFFFFFD", lo_o); end
    n_checks++; if (hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want FFFFFFFF", hi_o); end
    model_op(3'b011, 32'd100, 32'd7, k);
    do_op(3'b011, 32'd100, 32'd7, bn, gd, gz);
    n_checks++; if (lo_o !== 32'hE) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000E", lo_o); end
    n_checks++; if (hi_o !== 32'h2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi_o); end
    model_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, k);
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, bn, gd, gz);
    n_checks++; if (lo_o !== 32'h8000_0000 || hi_o !== 32'h0 || gz !== 1'b0) begin
      n_fail++; $display("FAIL div_min_m1: got lo %h hi %h dbz %b want 80000000 0 0", lo_o, hi_o, gz); end
    drive_move(3'b100, 32'hAAAA_0000);
    drive_move(3'b101, 32'h0000_5555);
    do_op(3'b011, 32'd100, 32'h0, bn, gd, gz);
    n_checks++; if (gd !== 1'b1 || gz !== 1'b1 || bn != 1) begin
      n_fail++; $display("FAIL div0_pulse: got done %b dbz %b busy %0d want 1 1 1", gd, gz, bn); end
    n_checks++; if (hi_o !== 32'hAAAA_0000 || lo_o !== 32'h5555) begin
      n_fail++; $display("FAIL div0_hilo: got %h %h want AAAA0000 00005555", hi_o, lo_o); end
    step();
    n_checks++; if (done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
      n_fail++; $display("FAIL div0_width: got done %b dbz %b want 0 0", done_o, div_by_zero_o); end
`else
    // Without the divider, DIV/DIVU must behave as undefined ops.
    start_i = 1'b1; op_i = 3'b010; a_i = 32'hFFFF_FFF9; b_i = 32'h2;
    step();
    start_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL nodiv_busy: got %b want 0", busy_o); end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o || div_by_zero_o) nd++;
      step();
    end
    n_checks++; if (nd != 0) begin n_fail++; $display("FAIL nodiv_done: got %0d pulses want 0", nd); end
    n_checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin
      n_fail++; $display("FAIL nodiv_hilo: got %h %h want %h %h", hi_o, lo_o, hi_m, lo_m); end
`endif
  endtask

  task automatic test_flush();
    int nd;
    drive_move(3'b100, 32'h0BAD_F00D);
    drive_move(3'b101, 32'h600D_CAFE);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'h1234; b_i = 32'h5678;
    step();
    start_i = 1'b0;
    repeat (9) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_run_busy: got %b want 0", busy_o); end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) nd++;
      step();
    end
    n_checks++; if (nd != 0) begin n_fail++; $display("FAIL flush_run_done: got %0d pulses want 0", nd); end
    n_checks++; if (hi_o !== 32'h0BAD_F00D || lo_o !== 32'h600D_CAFE) begin
      n_fail++; $display("FAIL flush_run_hilo: got %h %h want 0BADF00D 600DCAFE", hi_o, lo_o); end
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; a_i = 32'h3; b_i = 32'h3;
    step();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", busy_o); end
    op_i = 3'b100; a_i = 32'hFFFF_0000;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    n_checks++; if (hi_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL flush_mthi: got %h want 0BADF00D", hi_o); end
`ifdef MDU_DIV_EN
    start_i = 1'b1; op_i = 3'b011; a_i = 32'h9; b_i = 32'h0;
    step();
    start_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_fix: got busy %b done %b dbz %b want 0 0 0", busy_o, done_o, div_by_zero_o); end
`endif
  endtask

  task automatic test_busy_ignore();
    int k; bit gd;
    model_op(3'b000, 32'h8765_4321, 32'hFEDC_BA98, k);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'h8765_4321; b_i = 32'hFEDC_BA98;
    step();
    start_i = 1'b0;
    repeat (3) step();
    start_i = 1'b1; op_i = 3'b100; a_i = 32'hDEAD_BEEF;
    step();
    start_i = 1'b1; op_i = 3'b001; a_i = 32'h5; b_i = 32'h5;
    step();
    start_i = 1'b0;
    gd = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) begin gd = 1'b1; break; end
      step();
    end
    n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL busy_ign_done: got %b want 1", gd); end
    n_checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin
      n_fail++; $display("FAIL busy_ign_hilo: got %h %h want %h %h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_back_to_back();
    int bn, k; bit gd, gz;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    model_op(3'b000, a, b, k);
    do_op(3'b000, a, b, bn, gd, gz);
    a = $urandom; b = $urandom;
    model_op(3'b001, a, b, k);
    do_op(3'b001, a, b, bn, gd, gz);
    n_checks++; if (gd !== 1'b1 || bn != 33) begin
      n_fail++; $display("FAIL b2b_timing: got done %b busy %0d want 1 33", gd, bn); end
    n_checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin
      n_fail++; $display("FAIL b2b_hilo: got %h %h want %h %h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_random();
    int bn, k, sel; bit gd, gz;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) b = $urandom_range(1, 15);
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      model_op(op, a, b, k);
      if (k == KNone) begin
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        step();
        start_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || hi_o !== hi_m || lo_o !== lo_m) begin
          n_fail++; $display("FAIL rnd_short op %b: got busy %b %h %h want 0 %h %h", op, busy_o, hi_o, lo_o, hi_m, lo_m); end
      end else begin
        do_op(op, a, b, bn, gd, gz);
        n_checks++; if (gd !== 1'b1 || gz !== (k == KDbz) || bn != ((k == KDbz) ? 1 : 33)) begin
          n_fail++; $display("FAIL rnd_timing op %b: got done %b dbz %b busy %0d kind %0d", op, gd, gz, bn, k); end
        n_checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin
          n_fail++; $display("FAIL rnd_hilo op %b a %h b %h: got %h %h want %h %h", op, a, b, hi_o, lo_o, hi_m, lo_m); end
      end
      step();
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rnd_done_clear: got %b want 0", done_o); end
    end
  endtask

  task automatic test_reset_mid_run();
    drive_move(3'b100, 32'h1357_9BDF);
    drive_move(3'b101, 32'h2468_ACE0);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'h7777; b_i = 32'h3333;
    step();
    start_i = 1'b0;
    repeat (5) step();
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++; $display("FAIL async_rst_hilo: got %h %h want 0 0", hi_o, lo_o); end
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_ctl: got busy %b done %b dbz %b want 0 0 0", busy_o, done_o, div_by_zero_o); end
    step();
    reset = 1'b0; hi_m = 32'h0; lo_m = 32'h0;
    repeat (3) step();
    n_checks++; if (busy_o !== 1'b0 || hi_o !== 32'h0) begin
      n_fail++; $display("FAIL post_rst_idle: got busy %b hi %h want 0 0", busy_o, hi_o); end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
